// File: rtl/fir_decim_buffer_pkg.sv
// Shared constants for the FIR output path: sample width and the default
// decimation / buffering sizes used by fir_decim_buffer.
package fir_decim_buffer_pkg;

  localparam int FIR_OUT_W      = 10;
  localparam int DEF_LOG2_DECIM = 2;
  localparam int DEF_LOG2_DEPTH = 2;

  // Width of a counter that must exist even when its natural width is zero.
  function automatic int min1_width(input int w);
    return (w > 0) ? w : 1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: data_o always shows the head entry; a push into
// a full FIFO is accepted only when a pop frees the head in the same cycle.
module sync_fifo_fwft #(
  parameter int W          = 10,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                push_i,
  input  logic [W-1:0]        data_i,
  input  logic                pop_i,
  output logic [W-1:0]        data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [LOG2_DEPTH:0] level_o
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int LW    = LOG2_DEPTH + 1;
  localparam logic [LOG2_DEPTH-1:0] PTR_ONE  = 1;
  localparam logic [LW-1:0]         FULL_LVL = LW'(DEPTH);

  logic [W-1:0]          mem_q [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  pop_ok;
  logic                  push_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == FULL_LVL);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop on an empty FIFO is ignored; a full FIFO still accepts a push
  // when the head leaves on the same edge.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      level_d = level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok && !clr_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/fir_decim_buffer.sv
// Boxcar decimator behind the FIR: averages each group of 2^LOG2_DECIM valid
// samples and queues the results in a FWFT FIFO toward the consumer.
module fir_decim_buffer
  import fir_decim_buffer_pkg::*;
#(
  parameter int DW         = FIR_OUT_W,
  parameter int LOG2_DECIM = DEF_LOG2_DECIM,
  parameter int LOG2_DEPTH = DEF_LOG2_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DW-1:0]       in_data,
  input  logic                flush,
  output logic                out_valid,
  output logic [DW-1:0]       out_data,
  input  logic                out_ready,
  output logic [LOG2_DEPTH:0] level,
  output logic                overflow
);

  localparam int AW = DW + LOG2_DECIM;
  localparam int PW = min1_width(LOG2_DECIM);
  localparam logic [PW-1:0] LAST_PHASE = PW'((1 << LOG2_DECIM) - 1);
  localparam logic [PW-1:0] PHASE_ONE  = 1;

  logic [AW-1:0] acc_q, acc_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] sum;
  logic [DW-1:0] result;
  logic          last_phase;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;

  assign sum        = acc_q + AW'(in_data);
  assign result     = DW'(sum >> LOG2_DECIM);
  assign last_phase = (phase_q == LAST_PHASE);
  assign push       = in_valid && last_phase && !flush;
  assign pop        = out_valid && out_ready;

  always_comb begin
    acc_d      = acc_q;
    phase_d    = phase_q;
    overflow_d = overflow_q;
    if (flush) begin
      acc_d      = '0;
      phase_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (in_valid) begin
        if (last_phase) begin
          acc_d   = '0;
          phase_d = '0;
        end else begin
          acc_d   = sum;
          phase_d = phase_q + PHASE_ONE;
        end
      end
      // A result is lost only when the FIFO is full and nothing leaves.
      if (push && fifo_full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q      <= '0;
      phase_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo_fwft #(
    .W          (DW),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .clr_i   (flush),
    .push_i  (push),
    .data_i  (result),
    .pop_i   (out_ready),
    .data_o  (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign out_valid = !fifo_empty;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Bench for fir_decim_buffer: directed scenarios with literal expectations plus
// a randomized run, all compared every cycle against a queue-based model.
module tb_fir_decim_buffer;

  localparam int DW         = 10;
  localparam int LOG2_DECIM = 2;
  localparam int LOG2_DEPTH = 2;
  localparam int DEC        = 1 << LOG2_DECIM;
  localparam int DEPTH      = 1 << LOG2_DEPTH;

  // Clock / reset
  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                in_valid = 1'b0;
  logic [DW-1:0]       in_data = '0;
  logic                flush = 1'b0;
  logic                out_ready = 1'b0;
  logic                out_valid;
  logic [DW-1:0]       out_data;
  logic [LOG2_DEPTH:0] level;
  logic                overflow;

  always #5 clk = ~clk;

  fir_decim_buffer #(
    .DW         (DW),
    .LOG2_DECIM (LOG2_DECIM),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow)
  );

  // Scoreboard: behavioural model of the whole block
  logic [DW-1:0] exp_q[$];
  int            m_acc = 0;
  int            m_cnt = 0;
  bit            m_ovf = 1'b0;
  int            n_tests = 0;
  int            n_fail = 0;
  bit            chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
    exp_q.delete();
  endtask

  // Applies the inputs present at this clock edge to the model.
  task automatic model_step();
    bit            do_pop;
    bit            do_push;
    logic [DW-1:0] res;
    if (flush) begin
      model_clear();
      return;
    end
    do_pop  = (exp_q.size() != 0) && out_ready;
    do_push = 1'b0;
    res     = '0;
    if (in_valid) begin
      m_acc += int'(in_data);
      m_cnt++;
      if (m_cnt == DEC) begin
        res     = DW'(m_acc / DEC);
        do_push = 1'b1;
        m_acc   = 0;
        m_cnt   = 0;
      end
    end
    if (do_push && exp_q.size() == DEPTH && !do_pop) begin
      m_ovf = 1'b1;
    end else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(res);
    end
  endtask

  always @(negedge clk) begin
    if (rst && chk_en) begin
      check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
      check("level", int'(level), exp_q.size());
      check("overflow", int'(overflow), int'(m_ovf));
      if (exp_q.size() != 0) check("out_data", int'(out_data), int'(exp_q[0]));
    end
  end

  // Driver tasks
  task automatic tick(input bit v, input int d, input bit rdy, input bit fl);
    in_valid  = v;
    in_data   = DW'(d);
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic feed(input int d, input int n, input bit rdy);
    for (int i = 0; i < n; i++) tick(1'b1, d, rdy, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_clear();
    #1;
    check("rst_level", int'(level), 0);
    check("rst_out_valid", int'(out_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_level", int'(level), 0);
    check("reset_overflow", int'(overflow), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk_en = 1'b1;

    // Basic average 4,8,12,16 -> 10
    tick(1, 4, 1, 0); tick(1, 8, 1, 0); tick(1, 12, 1, 0);
    check("basic_not_yet", int'(out_valid), 0);
    tick(1, 16, 1, 0);
    check("basic_valid", int'(out_valid), 1);
    check("basic_data", int'(out_data), 10);
    tick(0, 0, 1, 0);
    check("basic_popped_level", int'(level), 0);

    // Full scale and truncation
    feed(1023, 4, 1'b0);
    check("full_scale", int'(out_data), 1023);
    tick(0, 0, 1, 0);
    tick(1, 1, 0, 0); tick(1, 1, 0, 0); tick(1, 1, 0, 0); tick(1, 0, 0, 0);
    check("truncation", int'(out_data), 0);
    check("truncation_valid", int'(out_valid), 1);
    tick(0, 0, 1, 0);

    // Gapped input
    for (int s = 1; s <= 4; s++) begin
      tick(1, 4 * s, 1, 0);
      if (s < 4) begin
        repeat (3) tick(0, 999, 1, 0);
        check("gap_no_result", int'(out_valid), 0);
      end
    end
    check("gap_data", int'(out_data), 10);
    tick(0, 0, 1, 0);

    // Overflow: 5 results into a depth-4 FIFO
    feed(100, 20, 1'b0);
    check("ovf_level", int'(level), 4);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_head", int'(out_data), 100);
    repeat (4) tick(0, 0, 1, 0);
    check("ovf_drained", int'(out_valid), 0);
    check("ovf_sticky", int'(overflow), 1);
    tick(0, 0, 0, 1);
    check("flush_clears_ovf", int'(overflow), 0);

    // Full with simultaneous push/pop
    for (int k = 1; k <= 4; k++) feed(10 * k, 4, 1'b0);
    check("fill_level", int'(level), 4);
    feed(50, 3, 1'b0);
    tick(1, 50, 1, 0);
    check("pushpop_level", int'(level), 4);
    check("pushpop_ovf", int'(overflow), 0);
    for (int k = 0; k < 4; k++) begin
      check("pushpop_order", int'(out_data), 20 + 10 * k);
      tick(0, 0, 1, 0);
    end
    check("pushpop_empty", int'(out_valid), 0);

    // Reset mid-decimation
    feed(7, 2, 1'b1);
    do_reset();
    feed(40, 4, 1'b1);
    check("post_reset_data", int'(out_data), 40);
    tick(0, 0, 1, 0);

    // Flush discards partial sums and the sample in the flush cycle
    feed(900, 3, 1'b1);
    tick(1, 1000, 1, 1);
    feed(8, 4, 1'b1);
    check("post_flush_data", int'(out_data), 8);
    tick(0, 0, 1, 0);

    // Flush at level 3 with overflow set
    feed(60, 20, 1'b0);
    tick(0, 0, 1, 0);
    check("pre_flush_level", int'(level), 3);
    check("pre_flush_ovf", int'(overflow), 1);
    tick(0, 0, 0, 1);
    check("flush_level", int'(level), 0);
    check("flush_out_valid", int'(out_valid), 0);
    check("flush_ovf", int'(overflow), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 9) < 7, $urandom_range(0, 1023),
           $urandom_range(0, 9) < (i % 600 < 300 ? 3 : 7),
           $urandom_range(0, 149) == 0);
    end
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 1), $urandom_range(0, 1023),
           $urandom_range(0, 1), 1'b0);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
